uart_rx_sampler: RTL
====================

Name: uart_rx_sampler

Overview:
- Asynchronous RS-232 receiver front end for the bus UART peripheral.
- Synchronises the raw rxd pin, detects start bits and mid-bit samples 8N1 frames using the runtime divide register.
- Produces one-cycle data strobes that write directly into the peripheral's rx FIFO.
- Sits between the FTDI pin and the rx FIFO.

Parameters:
- DATA_WIDTH, 8, data bits per frame; must equal UART_DATA_WIDTH.
- SYNC_STAGES, 2, flops in the rxd metastability synchroniser; minimum 2.
- MIN_DIVIDE, 4, floor applied to uart_divide.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rxd  in  1  raw serial input, idle high, asynchronous to clk
- uart_divide  in  32  clk cycles per bit (UART_CLK_FREQ/baud)
- uart_rx_data  out  DATA_WIDTH  last received byte, LSB first on the wire
- uart_rx_valid  out  1  one-cycle strobe: uart_rx_data holds a good frame
- uart_rx_err  out  1  one-cycle strobe: framing error
- active  out  1  high while a frame is being received

Behaviour:
- Synchroniser flops reset to 1. Idle line therefore produces no false edge after reset.
- The synchronised signal is called rxs. All decisions use rxs, so pin-to-detection latency is SYNC_STAGES cycles.
- Effective divide div_eff = max(uart_divide, MIN_DIVIDE). It is latched at start detection and held for the whole frame, so mid-frame register writes affect only the next frame.
- Baud counter is 32 bits and counts down. Bit index is a 3-bit counter.
- FSM states:
  - IDLE: on rxs=0, go to START. Load counter = (div_eff>>1)-1 and set active=1.
  - START: at counter=0, sample rxs.
    - rxs=1 (false start / glitch): return to IDLE. active=0, no strobes.
    - rxs=0: go to DATA. Load counter = div_eff-1 and bit index = 0.
  - DATA: at counter=0, shift rxs into bit[index] and reload the counter. After index DATA_WIDTH-1, go to STOP.
  - STOP: at counter=0, sample rxs.
    - rxs=1: register the shift value into uart_rx_data and pulse uart_rx_valid on the next cycle. Go to IDLE, active=0.
    - rxs=0: update uart_rx_data, pulse uart_rx_err (valid stays 0), go to WAIT_IDLE.
  - WAIT_IDLE (break or line held low): stay until rxs=1, then IDLE with active=0. No further error strobes.
- Returning to IDLE at the stop-bit midpoint allows back-to-back frames. The next start edge arrives about half a bit later and must be caught.
- uart_rx_valid and uart_rx_err are never high together and never high for two consecutive cycles.
- Reset values: uart_rx_data=0, uart_rx_valid=0, uart_rx_err=0, active=0, state=IDLE.
- Reset mid-frame aborts the frame with no strobes.
- Latency at div_eff=D, t0 = first cycle rxs=0:
  - Start sample at t0+D/2.
  - Data bit i at t0+D/2+D(i+1).
  - Stop bit at t0+D/2+9D.
  - Strobe at t0+D/2+9D+1.
- The block has no backpressure. The consumer, the rx FIFO, must accept every strobe; overflow is accounted for downstream.

Decomposition:
- uart_defines.vh holds UART_DATA_WIDTH and the state encoding localparams (IDLE, START, DATA, STOP, WAIT_IDLE) as a shared enum.
- Existing UART_CLK_FREQ and UART_DEFAULT_BAUDRATE constants are used by the bench.
- One sub-module: sync_ff (parameterised SYNC_STAGES shift register with reset value 1). It is reused later for other async pins.

Test Plan:
- Single frame: divide=16, send 0xA5 8N1 from idle. Required: uart_rx_valid pulses once at t0+153 with uart_rx_data=0xA5; uart_rx_err stays 0; active high from t0 to t0+152.
- Back-to-back: divide=16, send 0x00, 0xFF, 0x55 with no idle gap. Required: three valid strobes 160 cycles apart with data 0x00, 0xFF, 0x55.
- Glitch rejection: divide=16, drive rxd low for 3 cycles only. Required: active pulses, then returns to 0 by t0+8; no valid, no err.
- Framing error and break: divide=16, send 0x3C with stop bit 0, then hold rxd low for 100 cycles. Required: single uart_rx_err pulse at t0+153, no valid, active held until rxs returns high. A following 0x81 frame is received cleanly.
- Divide floor and mid-frame change: set divide=2 and send 0x5A at 4 clk/bit, expecting data=0x5A. Then change divide from 16 to 32 during a 16-cycle frame; that frame is still received correctly and the next frame uses 32.
- Reset mid-frame: assert rst for 1 cycle during data bit 4. Required: all outputs 0, no strobe for the aborted frame; the next full frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_sampler_pkg.sv
// Shared UART receive definitions: frame width, board clocking defaults,
// receiver state encoding and the divide floor helper.
package uart_rx_sampler_pkg;

    localparam int UART_DATA_WIDTH       = 8;
    localparam int UART_CLK_FREQ         = 50_000_000;
    localparam int UART_DEFAULT_BAUDRATE = 3_125_000;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    function automatic logic [31:0] div_floor(input logic [31:0] div, input logic [31:0] min_div);
        return (div < min_div) ? min_div : div;
    endfunction

endpackage

// File: rtl/uart_rx_sampler_sync_ff.sv
// Multi-flop synchroniser for asynchronous single-bit pins; resets to 1 so an
// idle-high line never shows a false edge coming out of reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 receiver front end: synchronises rxd, finds start bits and samples each
// bit at its midpoint using a divide latched per frame; strobes into the rx FIFO.
module uart_rx_sampler
    import uart_rx_sampler_pkg::*;
#(
    parameter int DATA_WIDTH  = UART_DATA_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_DIVIDE  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic [31:0]           uart_divide,
    output logic [DATA_WIDTH-1:0] uart_rx_data,
    output logic                  uart_rx_valid,
    output logic                  uart_rx_err,
    output logic                  active
);

    localparam int IDX_W = $clog2(DATA_WIDTH);

    logic rxs;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    rx_state_e             state_q, state_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [31:0]           div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [31:0]           div_eff;
    logic                  cnt_done;

    assign div_eff  = div_floor(uart_divide, 32'(MIN_DIVIDE));
    assign cnt_done = (cnt_q == 32'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // Divide is captured here so register writes mid-frame only affect the next frame.
                if (!rxs) begin
                    state_d = START;
                    div_d   = div_eff;
                    cnt_d   = (div_eff >> 1) - 32'd1;
                end
            end
            START: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (rxs) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    cnt_d   = div_q - 32'd1;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - 32'd1;
                end else begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = div_q - 32'd1;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == IDX_W'(DATA_WIDTH-1)) state_d = STOP;
                end
            end
            STOP: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - 32'd1;
                end else begin
                    // Leaving at the stop midpoint leaves half a bit to catch a back-to-back start.
                    data_d = shift_q;
                    if (rxs) begin
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign uart_rx_data  = data_q;
    assign uart_rx_valid = valid_q;
    assign uart_rx_err   = err_q;
    // Asserted from the first low rxs cycle so a start edge counts as receiving immediately.
    assign active        = (state_q != IDLE) || !rxs;

endmodule
